// File: rtl/noc_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : noc_pkg
//  Purpose  : Shared field widths, flit layout, request layout and the
//             injection-state encoding used by the NoC injection interface.
//  Contents : NODE_ID_W, PAYLOAD_W, FLIT_W
//             flit_t      - {payload, src, dest, valid}, 16 bits
//             inj_req_t   - buffered request {payload, dest}
//             inj_state_t - IDLE / WAIT / SEND
//             format_flit - builds an issued flit from a request
//  Revision : 1.0 - initial release
// ============================================================================
package noc_pkg;

    localparam int NODE_ID_W = 2;
    localparam int PAYLOAD_W = 11;
    localparam int FLIT_W    = 16;

    typedef struct packed {
        logic [PAYLOAD_W-1:0] payload;
        logic [NODE_ID_W-1:0] src;
        logic [NODE_ID_W-1:0] dest;
        logic                 valid;
    } flit_t;

    // Only payload and destination are buffered; source and valid are
    // constant per node and added when the flit is issued.
    typedef struct packed {
        logic [PAYLOAD_W-1:0] payload;
        logic [NODE_ID_W-1:0] dest;
    } inj_req_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        SEND = 2'd2
    } inj_state_t;

    function automatic flit_t format_flit(input inj_req_t req,
                                          input logic [NODE_ID_W-1:0] src);
        flit_t f;
        f.payload = req.payload;
        f.src     = src;
        f.dest    = req.dest;
        f.valid   = 1'b1;
        return f;
    endfunction

endpackage
`default_nettype wire

// File: rtl/noc_inj_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : noc_inj_fifo
//  Purpose  : Small synchronous FIFO holding injection requests.
//  Ports    : clk, reset (async, active-low)
//             push, wdata          - write side (caller guarantees not full)
//             pop, rdata           - read side, rdata is the current head
//             count                - occupancy, 0..DEPTH
//  Revision : 1.0 - initial release
// ============================================================================
module noc_inj_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 13
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [DATA_W-1:0]          wdata,
    input  logic                       pop,
    output logic [DATA_W-1:0]          rdata,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0]  r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W:0]     r_count;

    // Storage needs no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

    // DEPTH is a power of two, so pointers wrap by plain overflow.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign rdata = r_mem[r_rd_ptr];
    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/noc_inject_if.sv
`default_nettype none
// ============================================================================
//  Module   : noc_inject_if
//  Purpose  : NoC injection interface. Buffers producer requests and issues
//             them as 16-bit flits only in this node's TDM slot and only when
//             the NoC buffer has credit.
//  Ports    : clk, reset (async, active-low)
//             req_valid/req_ready/req_dest/req_payload - producer handshake
//             enable      - TDM slot grant
//             full, almost_full - NoC buffer status
//             write, dataOut    - registered flit output
//             fifo_level        - buffered request count
//             sent_cnt, stall_cnt - only with NOC_INJ_STATS_EN defined
//  Options  : NOC_INJ_STATS_EN adds saturating issue/stall counters.
//  Revision : 1.0 - initial release
// ============================================================================
module noc_inject_if
    import noc_pkg::*;
#(
    parameter logic [NODE_ID_W-1:0] NODE_ID = '0,
    parameter int                   DEPTH   = 4,
    parameter int                   WIDTH   = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [NODE_ID_W-1:0]       req_dest,
    input  logic [PAYLOAD_W-1:0]       req_payload,
    input  logic                       enable,
    input  logic                       full,
    input  logic                       almost_full,
    output logic                       write,
    output logic [WIDTH-1:0]           dataOut,
    output logic [$clog2(DEPTH):0]     fifo_level
`ifdef NOC_INJ_STATS_EN
    ,
    output logic [15:0]                sent_cnt,
    output logic [15:0]                stall_cnt
`endif
);

    localparam int                CNT_W      = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0]  c_full_lvl = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]  c_one      = CNT_W'(1);

    if (WIDTH != FLIT_W) begin : g_bad_width
        $error("noc_inject_if: WIDTH must be 16");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("noc_inject_if: DEPTH must be a power of 2 and >= 2");
    end

    logic [CNT_W-1:0]  w_count;
    inj_req_t          w_head;
    inj_req_t          w_req;
    logic              w_push;
    logic              w_pop;
    logic              w_pending;
    logic              w_credit_ok;
    logic              w_empty_next;

    logic              r_write;
    flit_t             r_data;
    inj_state_t        r_state;

    assign w_req.payload = req_payload;
    assign w_req.dest    = req_dest;

    // A full FIFO refuses pushes even when a pop happens in the same cycle.
    assign req_ready = (w_count != c_full_lvl);
    assign w_push    = req_valid && req_ready;
    assign w_pending = (w_count != '0);

    // `full` lags our own `write` by one cycle; right after issuing, the slot
    // just consumed is not yet reflected, so demand the stricter almost_full.
    assign w_credit_ok = r_write ? !almost_full : !full;
    assign w_pop       = enable && w_pending && w_credit_ok;

    assign w_empty_next = (w_count == '0 && !w_push) ||
                          (w_count == c_one && w_pop && !w_push);

    noc_inj_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W ($bits(inj_req_t))
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_push),
        .wdata (w_req),
        .pop   (w_pop),
        .rdata (w_head),
        .count (w_count)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_write <= 1'b0;
            r_data  <= '0;
        end else begin
            r_write <= w_pop;
            if (w_pop) begin
                r_data <= format_flit(w_head, NODE_ID);
            end
        end
    end

    // Observability-only state; outputs never depend on it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE:       r_state <= w_push ? WAIT : IDLE;
                WAIT, SEND: r_state <= w_pop ? SEND :
                                       (w_empty_next ? IDLE : WAIT);
                default:    r_state <= IDLE;
            endcase
        end
    end

`ifdef NOC_INJ_STATS_EN
    logic [15:0] r_sent_cnt;
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sent_cnt  <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_pop && r_sent_cnt != 16'hFFFF) begin
                r_sent_cnt <= r_sent_cnt + 16'd1;
            end
            if (enable && w_pending && !w_credit_ok && r_stall_cnt != 16'hFFFF) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
        end
    end

    assign sent_cnt  = r_sent_cnt;
    assign stall_cnt = r_stall_cnt;
`endif

    assign write      = r_write;
    assign dataOut    = r_data;
    assign fifo_level = w_count;

endmodule
`default_nettype wire
